// File: rtl/cpu_trace_fifo.sv
// -----------------------------------------------------------------------------
// cpu_trace_fifo
//
// Instruction trace buffer that sits behind the multicycle CPU. One record is
// captured per executed instruction, on the cycle the CPU's control FSM enters
// the decode state. By then the IR is loaded, so opcode and funct are valid.
// A record is {pc, opcode, funct, delta}. Delta is the number of enabled
// cycles since the previous record, and it saturates at 16'hFFFF.
//
// Records go into a first-word-fall-through FIFO. The host drains it through a
// valid/ready handshake. A record that arrives while the FIFO is full, with no
// pop in the same cycle, is discarded and counted in a saturating counter.
//
// Ports
//   clock      in   system clock, rising-edge active
//   reset      in   asynchronous active-high reset, clears all state
//   enable     in   capture enable; when low, the cycle counter also holds
//   clear      in   synchronous flush of FIFO, counters and edge detector
//   estado     in   CPU control state
//   pc         in   CPU PC register value
//   opcode     in   IR opcode field
//   funct      in   IR funct field
//   rd_ready   in   consumer accepts the head record this cycle
//   rd_valid   out  FIFO holds at least one record
//   rd_pc      out  head record PC (zero when empty)
//   rd_opcode  out  head record opcode (zero when empty)
//   rd_funct   out  head record funct (zero when empty)
//   rd_delta   out  head record cycle delta (zero when empty)
//   level      out  number of stored records, 0..DEPTH
//   full       out  level == DEPTH
//   dropped    out  saturating count of records lost to overflow
// -----------------------------------------------------------------------------
module cpu_trace_fifo #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AW           = 4,
  parameter logic [5:0]  DECODE_STATE = 6'd1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          clear,
  input  logic [5:0]    estado,
  input  logic [31:0]   pc,
  input  logic [5:0]    opcode,
  input  logic [5:0]    funct,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [31:0]   rd_pc,
  output logic [5:0]    rd_opcode,
  output logic [5:0]    rd_funct,
  output logic [15:0]   rd_delta,
  output logic [AW:0]   level,
  output logic          full,
  output logic [15:0]   dropped
);

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] delta;
  } trace_rec_t;

  localparam logic [AW:0] LEVEL_FULL  = (AW+1)'(DEPTH);
  localparam logic [5:0]  ESTADO_INIT = 6'h3F;  // reset value of the edge detector
  localparam logic [15:0] CNT_MAX     = 16'hFFFF;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  trace_rec_t        mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic [15:0]       dropped_q, dropped_d;
  logic [15:0]       cycle_cnt_q, cycle_cnt_d;
  logic [5:0]        prev_estado_q, prev_estado_d;

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  logic       capture;
  logic       pop;
  logic       push;
  logic       drop;
  logic       fifo_empty;
  logic       fifo_full;
  trace_rec_t new_rec;
  trace_rec_t head_rec;

  // Empty and full come from the occupancy count. Pointer equality alone cannot
  // tell an empty FIFO from a full one.
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LEVEL_FULL);

  // Capture only on entry to decode. A CPU that stays in decode for several
  // cycles (for example, stalled) still yields exactly one record.
  assign capture = enable && (estado == DECODE_STATE) && (prev_estado_q != DECODE_STATE);

  assign pop  = !fifo_empty && rd_ready;
  // When the FIFO is full, a pop in the same cycle frees the slot the new
  // record needs.
  assign push = capture && (!fifo_full || pop);
  assign drop = capture && fifo_full && !pop;

  assign new_rec = '{pc: pc, opcode: opcode, funct: funct, delta: cycle_cnt_q};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch. A path that skips
    // an assignment would otherwise infer a latch.
    prev_estado_d = estado;
    cycle_cnt_d   = cycle_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    dropped_d     = dropped_q;

    if (clear) begin
      prev_estado_d = ESTADO_INIT;
      cycle_cnt_d   = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      level_d       = '0;
      dropped_d     = '0;
    end else begin
      // Cycle delta: restart at 1 after a capture, so the capture edge
      // itself counts toward the next record.
      if (capture) begin
        cycle_cnt_d = 16'd1;
      end else if (enable && (cycle_cnt_q != CNT_MAX)) begin
        cycle_cnt_d = cycle_cnt_q + 16'd1;
      end

      // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

      unique case ({push, pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase

      if (drop && (dropped_q != CNT_MAX)) begin
        dropped_d = dropped_q + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    if (reset) begin
      prev_estado_q <= ESTADO_INIT;
      cycle_cnt_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      dropped_q     <= '0;
    end else begin
      prev_estado_q <= prev_estado_d;
      cycle_cnt_q   <= cycle_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      dropped_q     <= dropped_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Record storage
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset. Only slots below level_q are ever read, and
  // the outputs are zero-masked while empty, so stale contents are never seen.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= new_rec;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (FWFT: the head record is visible without a read strobe)
  // ---------------------------------------------------------------------------
  assign head_rec  = mem_q[rd_ptr_q];

  assign rd_valid  = !fifo_empty;
  assign rd_pc     = rd_valid ? head_rec.pc     : '0;
  assign rd_opcode = rd_valid ? head_rec.opcode : '0;
  assign rd_funct  = rd_valid ? head_rec.funct  : '0;
  assign rd_delta  = rd_valid ? head_rec.delta  : '0;

  assign level     = level_q;
  assign full      = fifo_full;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_cpu_trace_fifo.sv
// -----------------------------------------------------------------------------
// tb_cpu_trace_fifo
//
// Directed stimulus for cpu_trace_fifo. A queue-based reference model tracks
// the expected FIFO contents, the drop count and the cycle counter. A compare
// process checks every DUT output against that model on each falling edge.
// Literal expectations at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_cpu_trace_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam logic [5:0]  DEC   = 6'd1;

  logic          clock;
  logic          reset;
  logic          enable;
  logic          clear;
  logic [5:0]    estado;
  logic [31:0]   pc;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic          rd_ready;
  logic          rd_valid;
  logic [31:0]   rd_pc;
  logic [5:0]    rd_opcode;
  logic [5:0]    rd_funct;
  logic [15:0]   rd_delta;
  logic [AW:0]   level;
  logic          full;
  logic [15:0]   dropped;

  cpu_trace_fifo #(
    .DEPTH        (DEPTH),
    .AW           (AW),
    .DECODE_STATE (DEC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .clear     (clear),
    .estado    (estado),
    .pc        (pc),
    .opcode    (opcode),
    .funct     (funct),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_pc     (rd_pc),
    .rd_opcode (rd_opcode),
    .rd_funct  (rd_funct),
    .rd_delta  (rd_delta),
    .level     (level),
    .full      (full),
    .dropped   (dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_on  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a queue of records plus plain integer counters
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [5:0]  fn;
    int          delta;
  } rec_t;

  rec_t       m_q[$];
  int         m_dropped = 0;
  int         m_cnt     = 0;
  logic [5:0] m_prev    = 6'h3F;

  function automatic void model_flush();
    m_q.delete();
    m_dropped = 0;
    m_cnt     = 0;
    m_prev    = 6'h3F;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      model_flush();
    end else if (clear) begin
      model_flush();
    end else begin : step
      bit   was_full;
      bit   do_pop;
      bit   do_cap;
      rec_t r;
      was_full = (m_q.size() == DEPTH);
      do_pop   = (m_q.size() != 0) && rd_ready;
      do_cap   = enable && (estado == DEC) && (m_prev != DEC);
      if (do_pop) void'(m_q.pop_front());
      if (do_cap) begin
        if (!was_full || do_pop) begin
          r.pc = pc; r.op = opcode; r.fn = funct; r.delta = m_cnt;
          m_q.push_back(r);
        end else if (m_dropped < 65535) begin
          m_dropped++;
        end
        m_cnt = 1;
      end else if (enable && m_cnt < 65535) begin
        m_cnt++;
      end
      m_prev = estado;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    if (cmp_on) begin
      bit exp_valid;
      exp_valid = (m_q.size() != 0);
      check("m_valid",   {31'd0, rd_valid}, {31'd0, exp_valid});
      check("m_level",   32'(level),        32'(m_q.size()));
      check("m_full",    {31'd0, full},     {31'd0, (m_q.size() == DEPTH)});
      check("m_dropped", 32'(dropped),      32'(m_dropped));
      if (exp_valid) begin
        check("m_pc",     rd_pc,            m_q[0].pc);
        check("m_opcode", 32'(rd_opcode),   32'(m_q[0].op));
        check("m_funct",  32'(rd_funct),    32'(m_q[0].fn));
        check("m_delta",  32'(rd_delta),    32'(m_q[0].delta));
      end else begin
        check("m_pc_z",   rd_pc,            32'd0);
        check("m_data_z", {16'd0, rd_opcode, rd_funct, rd_delta[3:0]}, 32'd0);
        check("m_delta_z", 32'(rd_delta),   32'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // One cycle with the given CPU state and PC. Opcode and funct are derived
  // from the PC so each record carries distinct field values.
  task automatic cyc(input logic [5:0] est, input logic [31:0] p);
    estado = est;
    pc     = p;
    opcode = p[7:2];
    funct  = p[13:8] ^ 6'h15;
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    estado   = 6'd0;
    rd_ready = 1'b1;
    for (int k = 0; k < DEPTH + 4 && rd_valid; k++) begin
      @(posedge clock);
      #1;
    end
    rd_ready = 1'b0;
    check("drain_empty", {31'd0, rd_valid}, 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; rd_ready = 1'b0;
    estado = 6'd0; pc = '0; opcode = '0; funct = '0;
    repeat (2) @(posedge clock);
    #1;
    reset  = 1'b0;
    cmp_on = 1'b1;

    // Reset state
    check("rst_valid",   {31'd0, rd_valid}, 32'd0);
    check("rst_level",   32'(level),        32'd0);
    check("rst_full",    {31'd0, full},     32'd0);
    check("rst_dropped", 32'(dropped),      32'd0);
    check("rst_pc",      rd_pc,             32'd0);

    // rd_ready while empty is ignored
    rd_ready = 1'b1;
    @(posedge clock); #1;
    rd_ready = 1'b0;
    check("pop_empty_level", 32'(level), 32'd0);

    // Basic capture and latency: estado 0,1,2,3,0,1
    enable = 1'b1;
    cyc(6'd0, 32'h0);
    check("lat_not_yet", {31'd0, rd_valid}, 32'd0);
    cyc(6'd1, 32'h0);
    check("lat_valid",  {31'd0, rd_valid}, 32'd1);
    check("lat_pc",     rd_pc,             32'h0);
    check("lat_delta1", 32'(rd_delta),     32'd1);
    cyc(6'd2, 32'h8);
    cyc(6'd3, 32'h8);
    cyc(6'd0, 32'h8);
    cyc(6'd1, 32'h4);
    check("basic_level", 32'(level), 32'd2);
    check("basic_head",  rd_pc,      32'h0);
    rd_ready = 1'b1;
    cyc(6'd2, 32'h8);
    rd_ready = 1'b0;
    check("second_pc",    rd_pc,         32'h4);
    check("second_delta", 32'(rd_delta), 32'd4);
    check("second_level", 32'(level),    32'd1);

    // Stuck in decode: one record only
    repeat (5) cyc(6'd1, 32'h40);
    check("stuck_level", 32'(level), 32'd2);
    drain();

    // Overflow: 20 decode entries, no reads
    for (int i = 0; i < 20; i++) begin
      cyc(6'd0, 32'h0);
      cyc(6'd1, 32'h1000 + 32'(4 * i));
    end
    check("ovf_level",   32'(level),    32'd16);
    check("ovf_full",    {31'd0, full}, 32'd1);
    check("ovf_dropped", 32'(dropped),  32'd4);
    check("ovf_head",    rd_pc,         32'h1000);

    // Full FIFO, capture with a simultaneous pop
    cyc(6'd0, 32'h0);
    rd_ready = 1'b1;
    cyc(6'd1, 32'h2000);
    rd_ready = 1'b0;
    check("fpp_level",   32'(level),   32'd16);
    check("fpp_dropped", 32'(dropped), 32'd4);
    check("fpp_head",    rd_pc,        32'h1004);

    // Drain and confirm order: first 16 captures minus the popped head, then the tail
    estado   = 6'd0;
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("order_pc", rd_pc, (i < 15) ? 32'h1004 + 32'(4 * i) : 32'h2000);
      @(posedge clock); #1;
    end
    rd_ready = 1'b0;
    check("order_empty", {31'd0, rd_valid}, 32'd0);

    // Delta saturation
    estado = 6'd0;
    repeat (66000) @(posedge clock);
    #1;
    cyc(6'd1, 32'h3000);
    check("sat_delta", 32'(rd_delta), 32'hFFFF);
    rd_ready = 1'b1;
    cyc(6'd0, 32'h0);
    rd_ready = 1'b0;
    // Disabled cycles do not count
    enable = 1'b0;
    repeat (10) cyc(6'd0, 32'h0);
    enable = 1'b1;
    cyc(6'd0, 32'h0);
    cyc(6'd0, 32'h0);
    cyc(6'd1, 32'h3004);
    check("hold_delta", 32'(rd_delta), 32'd4);
    check("hold_pc",    rd_pc,         32'h3004);

    // Synchronous clear
    clear = 1'b1;
    cyc(6'd0, 32'h0);
    clear = 1'b0;
    check("clr_level",   32'(level),        32'd0);
    check("clr_valid",   {31'd0, rd_valid}, 32'd0);
    check("clr_dropped", 32'(dropped),      32'd0);

    // Build level = 5, dropped = 2: 18 captures, then 11 pops
    for (int i = 0; i < 18; i++) begin
      cyc(6'd0, 32'h0);
      cyc(6'd1, 32'h5000 + 32'(4 * i));
    end
    rd_ready = 1'b1;
    repeat (11) cyc(6'd0, 32'h0);
    rd_ready = 1'b0;
    check("pre_rst_level",   32'(level),   32'd5);
    check("pre_rst_dropped", 32'(dropped), 32'd2);
    check("pre_rst_head",    rd_pc,        32'h502C);

    // Async reset pulse between edges
    #1 reset = 1'b1;
    #1;
    check("arst_level",   32'(level),        32'd0);
    check("arst_valid",   {31'd0, rd_valid}, 32'd0);
    check("arst_dropped", 32'(dropped),      32'd0);
    check("arst_pc",      rd_pc,             32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    cyc(6'd0, 32'h0);
    cyc(6'd1, 32'h6000);
    check("post_rst_level", 32'(level),    32'd1);
    check("post_rst_delta", 32'(rd_delta), 32'd2);
    check("post_rst_pc",    rd_pc,         32'h6000);

    repeat (2) @(posedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
